// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL RESETB, waits for a qualified LOCK and releases
// the downstream reset, with saturating retry and lock-loss statistics.
module pll_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 16,
   parameter int ERR_W         = 8
) (
   input  logic             clock_in,
   input  logic             resetn,
   input  logic             locked,
   input  logic             relock_req,
   input  logic             clear_stats,
   output logic             pll_resetb,
   output logic             sys_rst_n,
   output logic             ready,
   output logic [1:0]       state,
   output logic [ERR_W-1:0] retry_cnt,
   output logic [ERR_W-1:0] loss_cnt
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic             lock_meta_r;
   logic             lock_sync_r;
   logic             retry_inc_s;
   logic             loss_inc_s;

   assign state = state_r;

   // Next-state decision; relock_req outranks every lock-based transition.
   always_comb begin
      state_nx_s  = state_r;
      retry_inc_s = 1'b0;
      loss_inc_s  = 1'b0;
      case (state_r)
         ST_PLL_RST: begin
            if (cnt_r == RST_LAST) begin
               state_nx_s = ST_WAIT_LOCK;
            end else begin
               state_nx_s = ST_PLL_RST;
            end
         end
         ST_WAIT_LOCK: begin
            if (relock_req) begin
               state_nx_s = ST_PLL_RST;
            end else if (lock_sync_r) begin
               state_nx_s = ST_STABLE;
            end else if (cnt_r == LOCK_LAST) begin
               state_nx_s  = ST_PLL_RST;
               retry_inc_s = 1'b1;
            end else begin
               state_nx_s = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (relock_req) begin
               state_nx_s = ST_PLL_RST;
            end else if (!lock_sync_r) begin
               state_nx_s = ST_WAIT_LOCK;
            end else if (cnt_r == STABLE_LAST) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_STABLE;
            end
         end
         ST_RUN: begin
            if (relock_req) begin
               state_nx_s = ST_PLL_RST;
            end else if (!lock_sync_r) begin
               state_nx_s = ST_PLL_RST;
               loss_inc_s = 1'b1;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         default: begin
            state_nx_s = ST_PLL_RST;
         end
      endcase
   end

   // Synchroniser, state, phase counter and outputs decoded from the next state.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
         state_r     <= ST_PLL_RST;
         cnt_r       <= '0;
         pll_resetb  <= 1'b0;
         sys_rst_n   <= 1'b0;
         ready       <= 1'b0;
      end else begin
         lock_meta_r <= locked;
         lock_sync_r <= lock_meta_r;
         state_r     <= state_nx_s;
         if (state_nx_s != state_r) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         pll_resetb <= (state_nx_s != ST_PLL_RST);
         sys_rst_n  <= (state_nx_s == ST_RUN);
         ready      <= (state_nx_s == ST_RUN);
      end
   end

   // Saturating statistics; a clear request overrides a same-cycle increment.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else if (clear_stats) begin
         retry_cnt <= '0;
         loss_cnt  <= '0;
      end else begin
         if (retry_inc_s && (retry_cnt != ERR_MAX)) begin
            retry_cnt <= retry_cnt + ERR_W'(1);
         end else begin
            retry_cnt <= retry_cnt;
         end
         if (loss_inc_s && (loss_cnt != ERR_MAX)) begin
            loss_cnt <= loss_cnt + ERR_W'(1);
         end else begin
            loss_cnt <= loss_cnt;
         end
      end
   end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: phase/time-in-phase reference model checked every
// cycle, plus directed scenarios with hand-computed edge-by-edge expectations.
module tb_pll_supervisor;

   localparam int RST_C  = 4;
   localparam int LOCK_C = 20;
   localparam int STAB_C = 8;
   localparam int ERR_W  = 2;
   localparam int SAT    = 3;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             locked = 1'b0;
   logic             relock_req = 1'b0;
   logic             clear_stats = 1'b0;
   logic             pll_resetb;
   logic             sys_rst_n;
   logic             ready;
   logic [1:0]       state;
   logic [ERR_W-1:0] retry_cnt;
   logic [ERR_W-1:0] loss_cnt;

   int checks = 0;
   int failures = 0;

   pll_supervisor #(
      .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_C), .STABLE_CYCLES(STAB_C),
      .CNT_W(16), .ERR_W(ERR_W)
   ) dut (
      .clock_in(clk), .resetn(resetn), .locked(locked), .relock_req(relock_req),
      .clear_stats(clear_stats), .pll_resetb(pll_resetb), .sys_rst_n(sys_rst_n),
      .ready(ready), .state(state), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase, cycles spent in phase, 2-deep lock delay line.
   int ph = 0;
   int entry = 0;
   int cyc = 0;
   int m_retry = 0;
   int m_loss = 0;
   bit m_valid = 1'b0;
   bit hq[$];

   always @(posedge clk) begin
      int held;
      int nph;
      bit ls;
      bit rinc;
      bit linc;
      cyc++;
      if (!resetn) begin
         ph = 0;
         entry = cyc;
         hq.delete();
         hq.push_back(1'b0);
         hq.push_back(1'b0);
         m_retry = 0;
         m_loss = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         ls = hq.pop_front();
         hq.push_back(locked);
         held = cyc - entry;
         nph = ph;
         rinc = 1'b0;
         linc = 1'b0;
         if (ph != 0 && relock_req) nph = 0;
         else if (ph == 0) begin
            if (held >= RST_C) nph = 1;
         end else if (ph == 1) begin
            if (ls) nph = 2;
            else if (held >= LOCK_C) begin nph = 0; rinc = 1'b1; end
         end else if (ph == 2) begin
            if (!ls) nph = 1;
            else if (held >= STAB_C) nph = 3;
         end else if (!ls) begin
            nph = 0;
            linc = 1'b1;
         end
         if (nph != ph) entry = cyc;
         ph = nph;
         if (clear_stats) begin
            m_retry = 0;
            m_loss = 0;
         end else begin
            if (rinc && m_retry < SAT) m_retry++;
            if (linc && m_loss < SAT) m_loss++;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_state", 32'(state), 32'(ph));
         chk("model_pll_resetb", 32'(pll_resetb), 32'(ph != 0));
         chk("model_sys_rst_n", 32'(sys_rst_n), 32'(ph == 3));
         chk("model_ready", 32'(ready), 32'(ph == 3));
         chk("model_retry_cnt", 32'(retry_cnt), 32'(m_retry));
         chk("model_loss_cnt", 32'(loss_cnt), 32'(m_loss));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic lk);
      locked = lk;
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lowcnt;
      @(negedge clk);

      // Lock present from release: RESETB rises at edge 4, STABLE at 5, RUN at 13.
      do_reset(1'b1);
      tick(3);  chk("s1_pllrb_e3", 32'(pll_resetb), 32'd0);
                chk("s1_state_e3", 32'(state), 32'd0);
      tick(1);  chk("s1_pllrb_e4", 32'(pll_resetb), 32'd1);
                chk("s1_state_e4", 32'(state), 32'd1);
      tick(1);  chk("s1_state_e5", 32'(state), 32'd2);
      tick(7);  chk("s1_sysrst_e12", 32'(sys_rst_n), 32'd0);
      tick(1);  chk("s1_sysrst_e13", 32'(sys_rst_n), 32'd1);
                chk("s1_ready_e13", 32'(ready), 32'd1);
                chk("s1_state_e13", 32'(state), 32'd3);

      // Lock loss in RUN: sys_rst_n falls on the third edge, loss_cnt counts.
      locked = 1'b0;
      tick(2);  chk("s3_sysrst_e2", 32'(sys_rst_n), 32'd1);
      tick(1);  chk("s3_sysrst_e3", 32'(sys_rst_n), 32'd0);
                chk("s3_loss", 32'(loss_cnt), 32'd1);
                chk("s3_state", 32'(state), 32'd0);
      locked = 1'b1;
      for (int i = 0; i < 40 && ready !== 1'b1; i++) tick(1);
      chk("s3_relock_ready", 32'(ready), 32'd1);

      // One-cycle resetn pulse in RUN.
      resetn = 1'b0;
      tick(1);  chk("s6_state", 32'(state), 32'd0);
                chk("s6_pllrb", 32'(pll_resetb), 32'd0);
                chk("s6_sysrst", 32'(sys_rst_n), 32'd0);
                chk("s6_ready", 32'(ready), 32'd0);
                chk("s6_loss", 32'(loss_cnt), 32'd0);
      resetn = 1'b1;
      tick(3);  chk("s6_pllrb_e3", 32'(pll_resetb), 32'd0);
      tick(1);  chk("s6_pllrb_e4", 32'(pll_resetb), 32'd1);

      // Lock glitch late in STABLE: WAIT at 12, STABLE at 13, RUN at 21.
      do_reset(1'b1);
      tick(9);  locked = 1'b0;
      tick(1);  locked = 1'b1;
      tick(2);  chk("s2_state_e12", 32'(state), 32'd1);
      tick(1);  chk("s2_state_e13", 32'(state), 32'd2);
      tick(7);  chk("s2_ready_e20", 32'(ready), 32'd0);
      tick(1);  chk("s2_ready_e21", 32'(ready), 32'd1);
                chk("s2_loss", 32'(loss_cnt), 32'd0);

      // No lock: retry every 24 cycles, clear wins at edge 48, saturation at 3.
      do_reset(1'b0);
      tick(23); chk("s4_pllrb_e23", 32'(pll_resetb), 32'd1);
                chk("s4_retry_e23", 32'(retry_cnt), 32'd0);
      tick(1);  chk("s4_retry_e24", 32'(retry_cnt), 32'd1);
      lowcnt = 0;
      for (int i = 0; i < 24; i++) begin
         if (pll_resetb == 1'b0) lowcnt++;
         if (i < 23) tick(1);
      end
      chk("s4_low_cycles", 32'(lowcnt), 32'd4);
      clear_stats = 1'b1;
      tick(1);  clear_stats = 1'b0;
                chk("s4_clear_wins", 32'(retry_cnt), 32'd0);
                chk("s4_pllrb_e48", 32'(pll_resetb), 32'd0);
      tick(24); chk("s4_retry_e72", 32'(retry_cnt), 32'd1);
      tick(24); chk("s4_retry_e96", 32'(retry_cnt), 32'd2);
      tick(24); chk("s4_retry_e120", 32'(retry_cnt), 32'd3);
      tick(24); chk("s4_retry_sat", 32'(retry_cnt), 32'd3);

      // relock_req coinciding with synchronised lock loss, then relock in PLL_RST.
      do_reset(1'b1);
      tick(13); chk("s5_state_run", 32'(state), 32'd3);
      locked = 1'b0;
      tick(2);  relock_req = 1'b1;
      tick(1);  relock_req = 1'b0;
                chk("s5_state_e16", 32'(state), 32'd0);
                chk("s5_loss", 32'(loss_cnt), 32'd0);
      tick(1);  relock_req = 1'b1;
      tick(1);  relock_req = 1'b0;
      tick(1);  chk("s5_pllrb_e19", 32'(pll_resetb), 32'd0);
      tick(1);  chk("s5_pllrb_e20", 32'(pll_resetb), 32'd1);
                chk("s5_state_e20", 32'(state), 32'd1);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
